// File: rtl/dm163_pkg.sv
// Shared constants, types and helpers for the DM163 column receiver.
// Build option: DM163_RX_GLITCH_FILTER_EN enables the s_clk/latch glitch filter.
package dm163_pkg;

    localparam int PIXELS_PER_COL = 8;
    localparam int BITS_PER_PIXEL = 24;
    localparam int N_BITS         = PIXELS_PER_COL * BITS_PER_PIXEL;

    typedef logic [BITS_PER_PIXEL-1:0] pixel_t;
    typedef logic [N_BITS-1:0]         col_bits_t;

    typedef enum logic [1:0] {
        SHIFT,
        HELD,
        COMMIT
    } rx_state_t;

    // True when exactly one bit of the channel strobe is set
    function automatic logic isOneHot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Index of the set bit of a one-hot channel strobe
    function automatic logic [2:0] oneHotIndex(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dm163_in_sync.sv
// Input conditioning for one asynchronous serial-side input (scalar or vector).
// Strobe inputs (IS_STROBE=1) deliver a one-cycle rising-edge pulse; data inputs
// deliver the conditioned level, kept time-aligned with the strobes.
// Build option: DM163_RX_GLITCH_FILTER_EN adds a 2-sample agreement filter on
// strobes and a matching 2-cycle delay on data inputs.
module dm163_in_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit IS_STROBE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_out
);

    // A chain shorter than two flops is not a safe synchroniser, so clamp it
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef DM163_RX_GLITCH_FILTER_EN
    localparam bit FILTER_BUILD = 1'b1;
`else
    localparam bit FILTER_BUILD = 1'b0;
`endif

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] w_syncOut;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] r_prev;

    // Metastability chain bringing the pin into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_syncOut = r_sync[STAGES-1];

    generate
        if (FILTER_BUILD) begin : g_filter
            logic [WIDTH-1:0] r_sample;
            logic [WIDTH-1:0] r_filt;
            logic [WIDTH-1:0] r_dly0;
            logic [WIDTH-1:0] r_dly1;
            logic [WIDTH-1:0] w_agree;

            assign w_agree = ~(w_syncOut ^ r_sample);

            // Filtered level follows only two equal consecutive samples; data is delayed to match
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sample <= '0;
                    r_filt   <= '0;
                    r_dly0   <= '0;
                    r_dly1   <= '0;
                end else begin
                    r_sample <= w_syncOut;
                    r_filt   <= (w_agree & w_syncOut) | (~w_agree & r_filt);
                    r_dly0   <= w_syncOut;
                    r_dly1   <= r_dly0;
                end
            end

            assign w_cond = IS_STROBE ? r_filt : r_dly1;
        end else begin : g_direct
            assign w_cond = w_syncOut;
        end
    endgenerate

    // Registered copy of the conditioned level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_cond;
        end
    end

    assign o_out = IS_STROBE ? (w_cond & ~r_prev) : w_cond;

endmodule

// File: rtl/dm163_column_receiver.sv
// Receive side of the colour-shield column driver: deserialises column words,
// decodes the one-hot channel strobe and rebuilds the 8x8 RGB frame in a store
// with a registered pixel read port.
// Build option: DM163_RX_GLITCH_FILTER_EN filters short s_clk/latch glitches.
module dm163_column_receiver
    import dm163_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_clk,
    input  logic        s_sda,
    input  logic        latch,
    input  logic [7:0]  channel,
    input  logic        clr_err,
    input  logic [5:0]  rd_addr,
    output logic [23:0] rd_pixel,
    output logic        col_valid,
    output logic [2:0]  col_idx,
    output logic        frame_done,
    output logic        err_bitcount,
    output logic        err_channel,
    output logic        err_overrun
);

    logic      w_sclkRise;
    logic      w_latchRise;
    logic      w_sda;
    logic [7:0] w_chan;

    col_bits_t r_shiftReg;
    col_bits_t r_hold;
    col_bits_t r_store [PIXELS_PER_COL];
    logic [7:0] r_bitCnt;
    rx_state_t r_state;
    rx_state_t w_nextState;
    logic [2:0] r_colIdx;
    logic      w_commit;
    logic      w_loadIdx;
    logic      w_bitErr;
    logic      w_chanErr;
    logic      w_overErr;

    dm163_in_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .IS_STROBE(1'b1)) u_sclkSync (
        .clk(clk), .rst_n(rst_n), .i_async(s_clk), .o_out(w_sclkRise)
    );

    dm163_in_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .IS_STROBE(1'b1)) u_latchSync (
        .clk(clk), .rst_n(rst_n), .i_async(latch), .o_out(w_latchRise)
    );

    dm163_in_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .IS_STROBE(1'b0)) u_sdaSync (
        .clk(clk), .rst_n(rst_n), .i_async(s_sda), .o_out(w_sda)
    );

    dm163_in_sync #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .IS_STROBE(1'b0)) u_chanSync (
        .clk(clk), .rst_n(rst_n), .i_async(channel), .o_out(w_chan)
    );

    // MSB-first shift path with a saturating bit counter; a latch restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shiftReg <= '0;
            r_bitCnt   <= 8'd0;
        end else begin
            if (w_sclkRise) begin
                r_shiftReg <= {r_shiftReg[N_BITS-2:0], w_sda};
            end
            if (w_latchRise) begin
                r_bitCnt <= 8'd0;
            end else if (w_sclkRise && (r_bitCnt != 8'd255)) begin
                r_bitCnt <= r_bitCnt + 8'd1;
            end
        end
    end

    // Latch copies the pre-shift word into the hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_latchRise) begin
            r_hold <= r_shiftReg;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SHIFT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a new latch always wins, otherwise a one-hot channel commits the held word
    always_comb begin
        w_nextState = r_state;
        w_commit    = 1'b0;
        w_loadIdx   = 1'b0;
        case (r_state)
            SHIFT: begin
                if (w_latchRise) begin
                    w_nextState = HELD;
                end
            end
            HELD: begin
                if (w_latchRise) begin
                    w_nextState = HELD;
                end else if (isOneHot(w_chan)) begin
                    w_loadIdx   = 1'b1;
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_nextState = w_latchRise ? HELD : SHIFT;
            end
            default: begin
                w_nextState = SHIFT;
            end
        endcase
    end

    // Capture the decoded column index on the way into COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_colIdx <= 3'd0;
        end else if (w_loadIdx) begin
            r_colIdx <= oneHotIndex(w_chan);
        end
    end

    // Capture store: one column word per column, written on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < PIXELS_PER_COL; c++) begin
                r_store[c] <= '0;
            end
        end else if (w_commit) begin
            r_store[r_colIdx] <= r_hold;
        end
    end

    // Registered read port; a same-cycle commit is not forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pixel <= '0;
        end else begin
            rd_pixel <= r_store[rd_addr[5:3]][rd_addr[2:0]*BITS_PER_PIXEL +: BITS_PER_PIXEL];
        end
    end

    assign w_bitErr  = w_latchRise && (r_bitCnt != 8'(N_BITS));
    assign w_overErr = w_latchRise && (r_state == HELD);
    assign w_chanErr = (r_state == HELD) && (w_chan != 8'd0) && !isOneHot(w_chan);

    // Sticky error flags; a new error event takes priority over clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bitcount <= 1'b0;
            err_channel  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (w_bitErr) begin
                err_bitcount <= 1'b1;
            end else if (clr_err) begin
                err_bitcount <= 1'b0;
            end
            if (w_chanErr) begin
                err_channel <= 1'b1;
            end else if (clr_err) begin
                err_channel <= 1'b0;
            end
            if (w_overErr) begin
                err_overrun <= 1'b1;
            end else if (clr_err) begin
                err_overrun <= 1'b0;
            end
        end
    end

    assign col_valid  = w_commit;
    assign col_idx    = r_colIdx;
    assign frame_done = w_commit && (r_colIdx == 3'd7);

endmodule

// File: tb/tb_dm163_column_receiver.sv
// Self-checking bench for dm163_column_receiver.
// The reference model keeps the history of received bits and an 8x8 pixel array.
// Build option: DM163_RX_GLITCH_FILTER_EN changes the expected glitch behaviour.
module tb_dm163_column_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_clk;
    logic        s_sda;
    logic        latch;
    logic [7:0]  channel;
    logic        clr_err;
    logic [5:0]  rd_addr;
    logic [23:0] rd_pixel;
    logic        col_valid;
    logic [2:0]  col_idx;
    logic        frame_done;
    logic        err_bitcount;
    logic        err_channel;
    logic        err_overrun;

    int total = 0;
    int bad   = 0;
    int validCount = 0;
    int frameCount = 0;
    logic [2:0] lastIdx = 3'd0;

    bit          histQ[$];
    logic [191:0] mHold;
    logic [23:0] mPix [8][8];

    dm163_column_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_clk(s_clk), .s_sda(s_sda), .latch(latch),
        .channel(channel), .clr_err(clr_err), .rd_addr(rd_addr), .rd_pixel(rd_pixel),
        .col_valid(col_valid), .col_idx(col_idx), .frame_done(frame_done),
        .err_bitcount(err_bitcount), .err_channel(err_channel), .err_overrun(err_overrun)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Commit monitor counting col_valid/frame_done pulses away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (col_valid === 1'b1) begin
                validCount++;
                lastIdx = col_idx;
            end
            if (frame_done === 1'b1) begin
                frameCount++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] historyWord();
        logic [191:0] w;
        w = '0;
        foreach (histQ[i]) begin
            w = {w[190:0], histQ[i]};
        end
        return w;
    endfunction

    function automatic logic [191:0] randomWord();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pushHistory(input bit b);
        histQ.push_back(b);
        if (histQ.size() > 192) begin
            void'(histQ.pop_front());
        end
    endtask

    task automatic sendBit(input bit b);
        s_sda = b;
        tick(4);
        s_clk = 1'b1;
        tick(4);
        s_clk = 1'b0;
        pushHistory(b);
    endtask

    task automatic pulseLatch();
        tick(4);
        latch = 1'b1;
        tick(4);
        latch = 1'b0;
        tick(4);
        mHold = historyWord();
    endtask

    // Shift the low nbits of word MSB first, then latch
    task automatic applyStimulus(input logic [191:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sendBit(word[i]);
        end
        pulseLatch();
    endtask

    // Drive a channel strobe and expect exactly one commit to column idx
    task automatic commitTo(input int idx, input logic [7:0] chanVal);
        int start;
        start = validCount;
        channel = chanVal;
        for (int i = 0; i < 40 && validCount == start; i++) begin
            tick(1);
        end
        channel = 8'h00;
        tick(4);
        checkOutput("commit_count", validCount - start, 1);
        checkOutput("commit_idx", 32'(lastIdx), idx);
        for (int r = 0; r < 8; r++) begin
            mPix[idx][r] = mHold[r*24 +: 24];
        end
    endtask

    task automatic checkColumn(input int c);
        for (int r = 0; r < 8; r++) begin
            rd_addr = 6'(c * 8 + r);
            tick(1);
            checkOutput($sformatf("rd_pixel[%0d][%0d]", c, r), 32'(rd_pixel), 32'(mPix[c][r]));
        end
    endtask

    task automatic pulseClear();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rd_pixel", 32'(rd_pixel), 0);
        checkOutput("rst_col_valid", 32'(col_valid), 0);
        checkOutput("rst_col_idx", 32'(col_idx), 0);
        checkOutput("rst_frame_done", 32'(frame_done), 0);
        checkOutput("rst_err_bitcount", 32'(err_bitcount), 0);
        checkOutput("rst_err_channel", 32'(err_channel), 0);
        checkOutput("rst_err_overrun", 32'(err_overrun), 0);
    endtask

    task automatic clearModel();
        histQ.delete();
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                mPix[c][r] = 24'h0;
            end
        end
    endtask

    // Directed sequence with randomised column data
    initial begin
        logic [191:0] w;
        int vc;
        int fc;
        int expErr;

        rst_n = 1'b0; s_clk = 1'b0; s_sda = 1'b0; latch = 1'b0;
        channel = 8'h00; clr_err = 1'b0; rd_addr = 6'd0;
        clearModel();
        tick(3);
        checkResetOutputs();
        rst_n = 1'b1;
        tick(5);

        $display("[TB] column of 0xA5 to column 2");
        w = {8{24'hA5A5A5}};
        applyStimulus(w, 192);
        commitTo(2, 8'h04);
        checkColumn(2);
        checkOutput("a5_err_bitcount", 32'(err_bitcount), 0);
        checkOutput("a5_err_channel", 32'(err_channel), 0);
        checkOutput("a5_err_overrun", 32'(err_overrun), 0);

        $display("[TB] short word of 191 bits");
        applyStimulus(randomWord(), 191);
        checkOutput("short_err_bitcount", 32'(err_bitcount), 1);
        pulseClear();
        checkOutput("clr_err_bitcount", 32'(err_bitcount), 0);
        commitTo(3, 8'h08);
        checkColumn(3);

        $display("[TB] double latch overrun");
        applyStimulus(randomWord(), 192);
        checkOutput("pre_overrun", 32'(err_overrun), 0);
        vc = validCount;
        applyStimulus(randomWord(), 192);
        checkOutput("overrun_set", 32'(err_overrun), 1);
        checkOutput("overrun_no_commit", validCount - vc, 0);
        commitTo(0, 8'h01);
        checkColumn(0);
        pulseClear();
        checkOutput("overrun_cleared", 32'(err_overrun), 0);

        $display("[TB] multi-hot channel then column 7");
        applyStimulus(randomWord(), 192);
        vc = validCount;
        channel = 8'h03;
        tick(12);
        checkOutput("chan_err_set", 32'(err_channel), 1);
        checkOutput("chan_err_no_commit", validCount - vc, 0);
        channel = 8'h00;
        tick(6);
        fc = frameCount;
        commitTo(7, 8'h80);
        checkOutput("col7_frame_done", frameCount - fc, 1);
        checkColumn(7);
        pulseClear();
        checkOutput("chan_err_cleared", 32'(err_channel), 0);

        $display("[TB] full frame");
        vc = validCount;
        fc = frameCount;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                logic [5:0] cr;
                cr = 6'(c * 8 + r);
                w[r*24 +: 24] = {4{cr}};
            end
            applyStimulus(w, 192);
            commitTo(c, 8'(1 << c));
        end
        checkOutput("frame_valid_count", validCount - vc, 8);
        checkOutput("frame_done_count", frameCount - fc, 1);
        for (int c = 0; c < 8; c++) begin
            checkColumn(c);
        end
        checkOutput("frame_err_bitcount", 32'(err_bitcount), 0);

        $display("[TB] reset in the middle of a word");
        w = randomWord();
        for (int i = 191; i > 91; i--) begin
            sendBit(w[i]);
        end
        vc = validCount;
        rst_n = 1'b0;
        s_clk = 1'b0;
        clearModel();
        #2;
        checkResetOutputs();
        tick(3);
        rst_n = 1'b1;
        tick(5);
        checkOutput("reset_no_commit", validCount - vc, 0);
        applyStimulus(randomWord(), 192);
        checkOutput("post_reset_bitcount", 32'(err_bitcount), 0);
        commitTo(5, 8'h20);
        checkColumn(5);
        checkColumn(0);

        $display("[TB] one-cycle s_clk glitch");
        s_sda = 1'b0;
        tick(4);
        s_clk = 1'b1;
        tick(1);
        s_clk = 1'b0;
        tick(6);
`ifdef DM163_RX_GLITCH_FILTER_EN
        expErr = 0;
`else
        pushHistory(1'b0);
        expErr = 1;
`endif
        applyStimulus(randomWord(), 192);
        checkOutput("glitch_err_bitcount", 32'(err_bitcount), 32'(expErr));
        commitTo(6, 8'h40);
        checkColumn(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
